// File: rtl/threshold_debounce_fsm_pkg.sv
// Shared types for the threshold monitor: FSM state encoding, comparator
// sample classes and the flag classifier.
package threshold_mon_pkg;

   typedef enum logic [2:0] {
      ST_NORMAL     = 3'd0,
      ST_OVER_PEND  = 3'd1,
      ST_OVER_TRIP  = 3'd2,
      ST_UNDER_PEND = 3'd3,
      ST_UNDER_TRIP = 3'd4,
      ST_FAULT      = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      CLS_GT  = 2'd0,
      CLS_LT  = 2'd1,
      CLS_EQ  = 2'd2,
      CLS_BAD = 2'd3
   } sample_class_e;

   // Exactly one flag set is a legal comparator result; anything else is BAD.
   function automatic sample_class_e classify(input logic gt, input logic lt, input logic eq);
      case ({gt, lt, eq})
         3'b100:  return CLS_GT;
         3'b010:  return CLS_LT;
         3'b001:  return CLS_EQ;
         default: return CLS_BAD;
      endcase
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/threshold_debounce_fsm_if.sv
// Comparator sample bus plus the fault-acknowledge strobe.
interface threshold_debounce_fsm_if;
   logic sample_valid;
   logic gt;
   logic lt;
   logic eq;
   logic clear;

   modport master (output sample_valid, gt, lt, eq, clear);
   modport slave  (input  sample_valid, gt, lt, eq, clear);
endinterface

// File: rtl/threshold_debounce_fsm_sample_watchdog.sv
// Counts clocks since the last valid sample; timeout is a level that stays
// high while the count sits at TIMEOUT. TIMEOUT=0 disables the watchdog.
module sample_watchdog #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sample_valid,
   output logic timeout
);

   localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] TMAX = WDW'(TIMEOUT);

   logic [WDW-1:0] cnt;

   // Restart on every valid sample, otherwise count up and hold at TIMEOUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (sample_valid) begin
         cnt <= '0;
      end else if (cnt != TMAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign timeout = (TIMEOUT != 0) && (cnt == TMAX);

endmodule

// File: rtl/threshold_debounce_fsm.sv
// Debounce/trip controller behind the threshold comparator. Requires
// CONFIRM_CNT agreeing samples to trip, RELEASE_CNT non-tripping samples to
// release, and raises FAULT on malformed flags or a stalled sample stream.
// Build option STICKY_FAULT_EN: FAULT leaves only on clear (watchdog idle);
// otherwise FAULT also leaves on the next well-formed sample.
module threshold_debounce_fsm
   import threshold_mon_pkg::*;
#(
   parameter int CONFIRM_CNT = 4,
   parameter int RELEASE_CNT = 8,
   parameter int TIMEOUT     = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   threshold_debounce_fsm_if.slave   smp,
   output logic                      over_o,
   output logic                      under_o,
   output logic                      fault_o,
   output logic                      cutoff_o,
   output logic                      event_o,
   output logic [2:0]                state_o
);

   localparam logic [2:0] S_NORMAL     = ST_NORMAL;
   localparam logic [2:0] S_OVER_PEND  = ST_OVER_PEND;
   localparam logic [2:0] S_OVER_TRIP  = ST_OVER_TRIP;
   localparam logic [2:0] S_UNDER_PEND = ST_UNDER_PEND;
   localparam logic [2:0] S_UNDER_TRIP = ST_UNDER_TRIP;
   localparam logic [2:0] S_FAULT      = ST_FAULT;

   localparam int CW = $clog2(max_int(CONFIRM_CNT, RELEASE_CNT) + 1);
   localparam logic [CW-1:0] CONF_C = CW'(CONFIRM_CNT);
   localparam logic [CW-1:0] REL_C  = CW'(RELEASE_CNT);
   // With a single-sample confirm the pending states are skipped.
   localparam logic [2:0] OVER_ENTRY  = (CONFIRM_CNT == 1) ? S_OVER_TRIP  : S_OVER_PEND;
   localparam logic [2:0] UNDER_ENTRY = (CONFIRM_CNT == 1) ? S_UNDER_TRIP : S_UNDER_PEND;

   logic [2:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] rel, rel_nxt;
   logic          timeout;
   logic          bad, tmo, fault_exit;
   sample_class_e cls;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   sample_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (smp.sample_valid),
      .timeout      (timeout)
   );

   // Next-state and counter logic; fault conditions outrank everything.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rel_nxt   = rel;
      cls       = classify(smp.gt, smp.lt, smp.eq);
      bad       = smp.sample_valid && (cls == CLS_BAD);
      // A valid sample in the same cycle masks the timeout.
      tmo       = timeout && !smp.sample_valid;
`ifdef STICKY_FAULT_EN
      fault_exit = smp.clear && !timeout && !bad;
`else
      fault_exit = (smp.sample_valid && !bad) || (smp.clear && !tmo && !bad);
`endif
      if (state == S_FAULT) begin
         if (fault_exit) state_nxt = S_NORMAL;
      end else if (bad || tmo || (state > S_FAULT)) begin
         state_nxt = S_FAULT;
      end else if (smp.sample_valid) begin
         case (state)
            S_NORMAL: begin
               if (cls == CLS_GT)      state_nxt = OVER_ENTRY;
               else if (cls == CLS_LT) state_nxt = UNDER_ENTRY;
            end
            S_OVER_PEND: begin
               if (cls == CLS_GT) begin
                  if (sat_inc(cnt) >= CONF_C) state_nxt = S_OVER_TRIP;
                  else                        cnt_nxt   = sat_inc(cnt);
               end else if (cls == CLS_LT) begin
                  state_nxt = UNDER_ENTRY;
               end else begin
                  state_nxt = S_NORMAL;
               end
            end
            S_UNDER_PEND: begin
               if (cls == CLS_LT) begin
                  if (sat_inc(cnt) >= CONF_C) state_nxt = S_UNDER_TRIP;
                  else                        cnt_nxt   = sat_inc(cnt);
               end else if (cls == CLS_GT) begin
                  state_nxt = OVER_ENTRY;
               end else begin
                  state_nxt = S_NORMAL;
               end
            end
            S_OVER_TRIP: begin
               if (cls == CLS_GT)                 rel_nxt   = '0;
               else if (sat_inc(rel) >= REL_C)    state_nxt = S_NORMAL;
               else                               rel_nxt   = sat_inc(rel);
            end
            S_UNDER_TRIP: begin
               if (cls == CLS_LT)                 rel_nxt   = '0;
               else if (sat_inc(rel) >= REL_C)    state_nxt = S_NORMAL;
               else                               rel_nxt   = sat_inc(rel);
            end
            default: ;
         endcase
      end
      // Every state change restarts both counters; pending entry counts the
      // sample that caused it.
      if (state_nxt != state) begin
         cnt_nxt = ((state_nxt == S_OVER_PEND) || (state_nxt == S_UNDER_PEND)) ? CW'(1) : '0;
         rel_nxt = '0;
      end
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_NORMAL;
         cnt      <= '0;
         rel      <= '0;
         over_o   <= 1'b0;
         under_o  <= 1'b0;
         fault_o  <= 1'b0;
         cutoff_o <= 1'b0;
         event_o  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rel      <= rel_nxt;
         over_o   <= (state_nxt == S_OVER_TRIP);
         under_o  <= (state_nxt == S_UNDER_TRIP);
         fault_o  <= (state_nxt == S_FAULT);
         cutoff_o <= (state_nxt == S_OVER_TRIP) || (state_nxt == S_UNDER_TRIP) ||
                     (state_nxt == S_FAULT);
         event_o  <= (state_nxt != state) &&
                     ((state_nxt == S_OVER_TRIP) || (state_nxt == S_UNDER_TRIP) ||
                      (state_nxt == S_FAULT));
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_threshold_debounce_fsm.sv
// Directed bench for threshold_debounce_fsm (CONFIRM_CNT=4, RELEASE_CNT=8,
// TIMEOUT=100). Honours STICKY_FAULT_EN when defined.
module tb_threshold_debounce_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       over_o, under_o, fault_o, cutoff_o, event_o;
   logic [2:0] state_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   threshold_debounce_fsm_if bus ();

   threshold_debounce_fsm #(
      .CONFIRM_CNT (4),
      .RELEASE_CNT (8),
      .TIMEOUT     (100)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .smp      (bus),
      .over_o   (over_o),
      .under_o  (under_o),
      .fault_o  (fault_o),
      .cutoff_o (cutoff_o),
      .event_o  (event_o),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v, g, l, e, c;
      logic [2:0] st;
      logic       ev;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, g, l, e, c, input logic [2:0] st, input logic ev);
      vec_t r;
      r.v = v; r.g = g; r.l = l; r.e = e; r.c = c; r.st = st; r.ev = ev;
      tbl.push_back(r);
   endtask

   task automatic rep(input int n, input logic g, l, e, input logic [2:0] st);
      for (int k = 0; k < n; k++) add(1'b1, g, l, e, 1'b0, st, 1'b0);
   endtask

   task automatic drive(input logic v, g, l, e, c);
      bus.sample_valid = v;
      bus.gt = g;
      bus.lt = l;
      bus.eq = e;
      bus.clear = c;
   endtask

   // Expected outputs: trip/fault flags follow the hand-computed state.
   task automatic chk(input string name, input logic [2:0] st, input logic ev);
      logic [7:0] exp_v, act_v;
      logic eo, eu, ef;
      eo = (st == 3'd2);
      eu = (st == 3'd4);
      ef = (st == 3'd5);
      exp_v = {eo, eu, ef, eo | eu | ef, ev, st};
      act_v = {over_o, under_o, fault_o, cutoff_o, event_o, state_o};
      total_cnt++;
      if (act_v !== exp_v)
         $display("FAIL %s: got over/under/fault/cutoff/event/state=%b required %b", name, act_v, exp_v);
      else
         pass_cnt++;
   endtask

   task automatic step_chk(input string name, input logic v, g, l, e, c,
                           input logic [2:0] st, input logic ev);
      drive(v, g, l, e, c);
      @(negedge clk);
      chk(name, st, ev);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      // Over trip then release with a GT in the middle of the hold-off
      rep(3, 1, 0, 0, 3'd1); add(1, 1, 0, 0, 0, 3'd2, 1);
      rep(7, 0, 0, 1, 3'd2); rep(1, 1, 0, 0, 3'd2);
      rep(7, 0, 0, 1, 3'd2); rep(1, 0, 0, 1, 3'd0);
      // Three GT then EQ aborts
      rep(3, 1, 0, 0, 3'd1); rep(1, 0, 0, 1, 3'd0);
      // Direction change during confirm, under trip, release by GT
      rep(2, 1, 0, 0, 3'd1); rep(3, 0, 1, 0, 3'd3); add(1, 0, 1, 0, 0, 3'd4, 1);
      rep(7, 1, 0, 0, 3'd4); rep(1, 1, 0, 0, 3'd0);
      // Malformed flags
      add(1, 1, 1, 0, 0, 3'd5, 1);
`ifdef STICKY_FAULT_EN
      rep(1, 0, 0, 1, 3'd5);
`else
      rep(1, 0, 0, 1, 3'd0);
`endif
      add(0, 0, 0, 0, 1, 3'd0, 0);
      add(1, 0, 0, 0, 0, 3'd5, 1);
      add(1, 1, 1, 1, 1, 3'd5, 0);
      add(0, 0, 0, 0, 1, 3'd0, 0);
      // Idle cycles between samples do not advance the confirm count
      rep(1, 1, 0, 0, 3'd1); add(0, 1, 0, 0, 0, 3'd1, 0);
      rep(1, 1, 0, 0, 3'd1); add(0, 1, 0, 0, 0, 3'd1, 0);
      rep(1, 1, 0, 0, 3'd1); add(1, 1, 0, 0, 0, 3'd2, 1);
      rep(7, 0, 1, 0, 3'd2); rep(1, 0, 1, 0, 3'd0);
      // Switching from under-pending restarts the over count at 1
      rep(1, 0, 1, 0, 3'd3); rep(3, 1, 0, 0, 3'd1); add(1, 1, 0, 0, 0, 3'd2, 1);
      rep(7, 0, 0, 1, 3'd2); rep(1, 0, 0, 1, 3'd0);

      drive(0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset", 3'd0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         step_chk($sformatf("vec%0d", i), tbl[i].v, tbl[i].g, tbl[i].l, tbl[i].e, tbl[i].c,
                  tbl[i].st, tbl[i].ev);

      // Watchdog: a sample just before the limit keeps the block healthy
      drive(0, 0, 0, 0, 0);
      repeat (99) @(negedge clk);
      step_chk("wd_near_miss", 1, 0, 0, 1, 0, 3'd0, 1'b0);
      // Sample arriving while the timeout level is up wins over the fault
      drive(0, 0, 0, 0, 0);
      repeat (100) @(negedge clk);
      step_chk("wd_valid_wins", 1, 1, 0, 0, 0, 3'd1, 1'b0);
      // Stall long enough to fault
      drive(0, 0, 0, 0, 0);
      repeat (100) @(negedge clk);
      step_chk("wd_timeout", 0, 0, 0, 0, 0, 3'd5, 1'b1);
      step_chk("wd_clear_blocked", 0, 0, 0, 0, 1, 3'd5, 1'b0);
`ifdef STICKY_FAULT_EN
      step_chk("wd_eq_sticky", 1, 0, 0, 1, 0, 3'd5, 1'b0);
      step_chk("wd_clear_exit", 0, 0, 0, 0, 1, 3'd0, 1'b0);
`else
      step_chk("wd_eq_exit", 1, 0, 0, 1, 0, 3'd0, 1'b0);
      step_chk("wd_idle_normal", 0, 0, 0, 0, 0, 3'd0, 1'b0);
`endif

      // Asynchronous reset while tripped
      for (int k = 0; k < 3; k++)
         step_chk($sformatf("rst_pre_gt%0d", k), 1, 1, 0, 0, 0, 3'd1, 1'b0);
      step_chk("rst_pre_trip", 1, 1, 0, 0, 0, 3'd2, 1'b1);
      drive(0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 3'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++)
         step_chk($sformatf("post_rst_gt%0d", k), 1, 1, 0, 0, 0, 3'd1, 1'b0);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
